// File: rtl/my_lin_interp_gate.sv
// ---------------------------------------------------------------------------
// my_lin_interp_gate
// Trigger-gated linear interpolator. Slow signed samples (din_vld) are held
// in a one-entry pending register; each fast trig advances an exact integer
// ramp from the previous sample (base) to the newest one (target) in RATIO
// steps. The ramp is accumulated as base*RATIO + phase*diff, so each segment
// lands exactly on its target and never drifts.
//
// Ports
//   clk       in   system clock
//   n_rst     in   asynchronous active-low reset
//   din_vld   in   one-cycle strobe, din valid
//   din       in   32-bit signed input sample (slow rate)
//   trig      in   one-cycle output step request (fast rate)
//   dout      out  32-bit signed interpolated output, registered
//   dout_vld  out  one-cycle pulse, dout updated this cycle
//   underrun  out  pulse: segment ended with no pending sample
//   overrun   out  pulse: din_vld overwrote an unconsumed pending sample
//   active    out  high while ramping (S_RUN)
//
// state   | meaning
// S_EMPTY | no sample seen yet, dout held at 0
// S_PRIME | one sample known, trig repeats it
// S_RUN   | ramping from base to target, one step per trig
// S_STALL | segment finished with nothing pending, dout holds target
// ---------------------------------------------------------------------------
module my_lin_interp_gate #(
    parameter int RATIO  = 4,
    parameter int LOG2_R = $clog2(RATIO),
    parameter int ACC_W  = 33 + LOG2_R + 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        din_vld,
    input  logic [31:0] din,
    input  logic        trig,
    output logic [31:0] dout,
    output logic        dout_vld,
    output logic        underrun,
    output logic        overrun,
    output logic        active
);

    // RATIO=1 still needs a one-bit phase register to stay legal.
    localparam int              PH_W    = (LOG2_R > 0) ? LOG2_R : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);

    typedef enum logic [1:0] {S_EMPTY, S_PRIME, S_RUN, S_STALL} state_t;

    state_t                   state, state_nxt;
    logic [31:0]              pend, pend_nxt;
    logic                     pend_full, pend_full_nxt;
    logic [31:0]              base, base_nxt;
    logic [31:0]              target, target_nxt;
    logic signed [32:0]       diff, diff_nxt;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic [PH_W-1:0]          phase, phase_nxt;
    logic [31:0]              dout_nxt;
    logic                     dout_vld_nxt, underrun_nxt, overrun_nxt;

    logic                     consume, start_seg, load_direct;
    logic [31:0]              seg_base;
    logic signed [ACC_W-1:0]  pend_ext, acc_step, acc_shr;

    always_comb begin
        state_nxt     = state;
        pend_nxt      = pend;
        pend_full_nxt = pend_full;
        base_nxt      = base;
        target_nxt    = target;
        diff_nxt      = diff;
        acc_nxt       = acc;
        phase_nxt     = phase;
        dout_nxt      = dout;
        dout_vld_nxt  = 1'b0;
        underrun_nxt  = 1'b0;
        overrun_nxt   = 1'b0;
        consume       = 1'b0;
        start_seg     = 1'b0;
        load_direct   = 1'b0;
        seg_base      = target;

        pend_ext = {{(ACC_W-32){pend[31]}}, pend};
        acc_step = acc + {{(ACC_W-33){diff[32]}}, diff};
        acc_shr  = acc_step >>> LOG2_R;

        case (state)
            S_EMPTY: begin
                if (pend_full) begin
                    base_nxt   = pend;
                    target_nxt = pend;
                    acc_nxt    = pend_ext <<< LOG2_R;
                    consume    = 1'b1;
                    state_nxt  = S_PRIME;
                end
            end
            S_PRIME: begin
                if (trig && pend_full) begin
                    if (RATIO == 1) load_direct = 1'b1;
                    else begin
                        start_seg = 1'b1;
                        seg_base  = base;
                        state_nxt = S_RUN;
                    end
                end else if (trig) begin
                    dout_nxt     = base;
                    dout_vld_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (trig) begin
                    if (RATIO == 1) begin
                        if (pend_full) load_direct = 1'b1;
                        else begin
                            dout_vld_nxt = 1'b1;
                            underrun_nxt = 1'b1;
                            state_nxt    = S_STALL;
                        end
                    end else begin
                        acc_nxt      = acc_step;
                        phase_nxt    = phase + PH_W'(1);
                        dout_nxt     = acc_shr[31:0];
                        dout_vld_nxt = 1'b1;
                        // Last step lands on target*RATIO, so dout is exact.
                        if (phase == PH_LAST) begin
                            if (pend_full) start_seg = 1'b1;
                            else begin
                                underrun_nxt = 1'b1;
                                state_nxt    = S_STALL;
                            end
                        end
                    end
                end
            end
            S_STALL: begin
                if (trig && pend_full) begin
                    if (RATIO == 1) load_direct = 1'b1;
                    else begin
                        start_seg = 1'b1;
                        state_nxt = S_RUN;
                    end
                end else if (trig) begin
                    dout_vld_nxt = 1'b1;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase

        // acc already equals seg_base*RATIO whenever a segment starts, so
        // only the slope and phase need reloading.
        if (start_seg) begin
            base_nxt   = seg_base;
            target_nxt = pend;
            diff_nxt   = {pend[31], pend} - {seg_base[31], seg_base};
            phase_nxt  = '0;
            consume    = 1'b1;
        end

        if (load_direct) begin
            dout_nxt     = pend;
            dout_vld_nxt = 1'b1;
            base_nxt     = pend;
            target_nxt   = pend;
            acc_nxt      = pend_ext;
            consume      = 1'b1;
            state_nxt    = S_RUN;
        end

        // New sample wins; it only counts as overrun if the old one was
        // not consumed in this same cycle.
        if (din_vld) begin
            pend_nxt      = din;
            pend_full_nxt = 1'b1;
            overrun_nxt   = pend_full & ~consume;
        end else if (consume) begin
            pend_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_EMPTY;
            pend      <= '0;
            pend_full <= 1'b0;
            base      <= '0;
            target    <= '0;
            diff      <= '0;
            acc       <= '0;
            phase     <= '0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            pend_full <= pend_full_nxt;
            base      <= base_nxt;
            target    <= target_nxt;
            diff      <= diff_nxt;
            acc       <= acc_nxt;
            phase     <= phase_nxt;
            dout      <= dout_nxt;
            dout_vld  <= dout_vld_nxt;
            underrun  <= underrun_nxt;
            overrun   <= overrun_nxt;
        end
    end

    assign active = (state == S_RUN);

endmodule

// File: tb/tb_my_lin_interp_gate.sv
// ---------------------------------------------------------------------------
// tb_my_lin_interp_gate
// Self-checking bench for my_lin_interp_gate (RATIO=4). A behavioural model
// tracks the last known sample, the ramp endpoints and the step count, and
// predicts each output as floor((base*R + k*(target-base)) / R).
// ---------------------------------------------------------------------------
module tb_my_lin_interp_gate;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        din_vld = 1'b0;
    logic [31:0] din = '0;
    logic        trig = 1'b0;
    logic [31:0] dout;
    logic        dout_vld, underrun, overrun, active;

    int checks = 0;
    int errors = 0;

    my_lin_interp_gate #(.RATIO(R)) dut (
        .clk(clk), .n_rst(n_rst), .din_vld(din_vld), .din(din), .trig(trig),
        .dout(dout), .dout_vld(dout_vld), .underrun(underrun),
        .overrun(overrun), .active(active)
    );

    always #5 clk = ~clk;

    // model state
    bit     m_have, m_seg, m_pfull;
    longint m_pend, m_base, m_tgt, e_out;
    int     m_k;
    logic   e_vld, e_und, e_ovr, e_act;
    logic [31:0] e_dout;

    // stimulus lists
    logic        sv[$];
    logic [31:0] sd[$];
    logic        st[$];
    longint      outs[$];
    int          n_und, n_ovr;

    function automatic longint floordiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        m_have = 0; m_seg = 0; m_pfull = 0; m_pend = 0;
        m_base = 0; m_tgt = 0; m_k = 0; e_out = 0;
        e_vld = 0; e_und = 0; e_ovr = 0; e_act = 0; e_dout = '0;
    endtask

    task automatic model(input logic v, input logic [31:0] d, input logic t);
        bit cons;
        cons = 0;
        e_vld = 0; e_und = 0;
        if (!m_have) begin
            if (m_pfull) begin
                m_have = 1; m_base = m_pend; m_tgt = m_pend; cons = 1;
            end
        end else if (!m_seg) begin
            if (t) begin
                if (m_pfull) begin
                    m_base = m_tgt; m_tgt = m_pend; m_k = 0; m_seg = 1; cons = 1;
                end else begin
                    e_vld = 1; e_out = m_tgt;
                end
            end
        end else if (t) begin
            m_k++;
            e_vld = 1;
            e_out = floordiv(m_base * R + longint'(m_k) * (m_tgt - m_base), R);
            if (m_k == R) begin
                if (m_pfull) begin
                    m_base = m_tgt; m_tgt = m_pend; m_k = 0; cons = 1;
                end else begin
                    m_seg = 0; e_und = 1;
                end
            end
        end
        e_ovr = v && m_pfull && !cons;
        if (v) begin
            m_pfull = 1; m_pend = longint'($signed(d));
        end else if (cons) begin
            m_pfull = 0;
        end
        e_act  = m_seg;
        e_dout = e_out[31:0];
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic t);
        @(negedge clk);
        din_vld = v; din = d; trig = t;
        @(posedge clk);
        model(v, d, t);
        #1;
        if (dout_vld) outs.push_back(longint'($signed(dout)));
        if (underrun) n_und++;
        if (overrun)  n_ovr++;
    endtask

    task automatic apply_reset();
        din_vld = 0; din = '0; trig = 0;
        n_rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1;
        model_reset();
        outs.delete(); n_und = 0; n_ovr = 0;
        sv.delete(); sd.delete(); st.delete();
    endtask

    task automatic push(input logic v, input logic [31:0] d, input logic t);
        sv.push_back(v); sd.push_back(d); st.push_back(t);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (dout !== 32'd0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
        checks++; if ({dout_vld, underrun, overrun, active} !== 4'b0) begin errors++;
            $display("FAIL reset_flags got %b want 0000", {dout_vld, underrun, overrun, active}); end
        // start a ramp and cut it halfway
        push(1, 32'd0, 0); push(0, 0, 0); push(1, 32'd800, 0); push(0, 0, 1);
        push(0, 0, 1); push(0, 0, 1);
        foreach (sv[i]) begin
            step(sv[i], sd[i], st[i]);
            checks++; if (dout !== e_dout) begin errors++; $display("FAIL t1_dout cyc %0d got %h want %h", i, dout, e_dout); end
            checks++; if (dout_vld !== e_vld) begin errors++; $display("FAIL t1_vld cyc %0d got %b want %b", i, dout_vld, e_vld); end
            checks++; if (active !== e_act) begin errors++; $display("FAIL t1_active cyc %0d got %b want %b", i, active, e_act); end
        end
        @(negedge clk);
        din_vld = 0; trig = 0;
        #2 n_rst = 0;
        #1;
        model_reset();
        checks++; if (dout !== 32'd0) begin errors++; $display("FAIL t1_async_dout got %h want 0", dout); end
        checks++; if ({dout_vld, underrun, overrun, active} !== 4'b0) begin errors++;
            $display("FAIL t1_async_flags got %b want 0000", {dout_vld, underrun, overrun, active}); end
        @(negedge clk);
        n_rst = 1;
        step(0, 0, 1);
        checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL t1_first_trig vld got %b want 0", dout_vld); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL t1_first_trig active got %b want 0", active); end
    endtask

    task automatic test_ramp();
        longint exp_o[7] = '{0, 100, 200, 300, 400, 400, 400};
        apply_reset();
        push(1, 32'd0, 0); push(0, 0, 0); push(0, 0, 1); push(1, 32'd400, 0);
        repeat (7) push(0, 0, 1);
        foreach (sv[i]) begin
            step(sv[i], sd[i], st[i]);
            checks++; if (dout !== e_dout) begin errors++; $display("FAIL t2_dout cyc %0d got %h want %h", i, dout, e_dout); end
            checks++; if (dout_vld !== e_vld) begin errors++; $display("FAIL t2_vld cyc %0d got %b want %b", i, dout_vld, e_vld); end
            checks++; if (underrun !== e_und) begin errors++; $display("FAIL t2_underrun cyc %0d got %b want %b", i, underrun, e_und); end
            checks++; if (active !== e_act) begin errors++; $display("FAIL t2_active cyc %0d got %b want %b", i, active, e_act); end
        end
        checks++; if (outs.size() != 7) begin errors++; $display("FAIL t2_count got %0d want 7", outs.size()); end
        else foreach (exp_o[i]) begin
            checks++; if (outs[i] != exp_o[i]) begin errors++; $display("FAIL t2_value %0d got %0d want %0d", i, outs[i], exp_o[i]); end
        end
        checks++; if (n_und != 1) begin errors++; $display("FAIL t2_underrun_count got %0d want 1", n_und); end
    endtask

    task automatic test_floor();
        longint exp_o[4] = '{-1, -2, -3, -3};
        apply_reset();
        push(1, 32'd0, 0); push(0, 0, 0); push(1, 32'hFFFF_FFFD, 0);
        repeat (5) push(0, 0, 1);
        foreach (sv[i]) begin
            step(sv[i], sd[i], st[i]);
            checks++; if (dout !== e_dout) begin errors++; $display("FAIL t3_dout cyc %0d got %h want %h", i, dout, e_dout); end
            checks++; if (dout_vld !== e_vld) begin errors++; $display("FAIL t3_vld cyc %0d got %b want %b", i, dout_vld, e_vld); end
        end
        checks++; if (outs.size() != 4) begin errors++; $display("FAIL t3_count got %0d want 4", outs.size()); end
        else foreach (exp_o[i]) begin
            checks++; if (outs[i] != exp_o[i]) begin errors++; $display("FAIL t3_value %0d got %0d want %0d", i, outs[i], exp_o[i]); end
        end
    endtask

    task automatic test_extremes();
        apply_reset();
        push(1, 32'h7FFF_FFFF, 0); push(0, 0, 0); push(1, 32'h8000_0000, 0);
        repeat (5) push(0, 0, 1);
        foreach (sv[i]) begin
            step(sv[i], sd[i], st[i]);
            checks++; if (dout !== e_dout) begin errors++; $display("FAIL t4_dout cyc %0d got %h want %h", i, dout, e_dout); end
            checks++; if (dout_vld !== e_vld) begin errors++; $display("FAIL t4_vld cyc %0d got %b want %b", i, dout_vld, e_vld); end
        end
        checks++; if (outs.size() != 4) begin errors++; $display("FAIL t4_count got %0d want 4", outs.size()); end
        else begin
            for (int i = 1; i < 4; i++) begin
                checks++; if (!(outs[i] < outs[i-1])) begin errors++; $display("FAIL t4_monotone %0d got %0d after %0d", i, outs[i], outs[i-1]); end
            end
            checks++; if (outs[3] != -64'sd2147483648) begin errors++; $display("FAIL t4_last got %0d want -2147483648", outs[3]); end
        end
    endtask

    task automatic test_overrun();
        longint exp_o[5] = '{10, 15, 20, 25, 30};
        apply_reset();
        push(1, 32'd10, 0); push(0, 0, 0); push(0, 0, 1);
        push(1, 32'd20, 0); push(1, 32'd30, 0); push(0, 0, 0);
        repeat (5) push(0, 0, 1);
        foreach (sv[i]) begin
            step(sv[i], sd[i], st[i]);
            checks++; if (dout !== e_dout) begin errors++; $display("FAIL t5_dout cyc %0d got %h want %h", i, dout, e_dout); end
            checks++; if (overrun !== e_ovr) begin errors++; $display("FAIL t5_overrun cyc %0d got %b want %b", i, overrun, e_ovr); end
        end
        checks++; if (n_ovr != 1) begin errors++; $display("FAIL t5_overrun_count got %0d want 1", n_ovr); end
        checks++; if (outs.size() != 5) begin errors++; $display("FAIL t5_count got %0d want 5", outs.size()); end
        else foreach (exp_o[i]) begin
            checks++; if (outs[i] != exp_o[i]) begin errors++; $display("FAIL t5_value %0d got %0d want %0d", i, outs[i], exp_o[i]); end
        end
    endtask

    task automatic test_back_to_back();
        longint exp_o[8] = '{25, 50, 75, 100, 125, 150, 175, 200};
        apply_reset();
        push(1, 32'd0, 0); push(0, 0, 0); push(1, 32'd100, 0); push(0, 0, 1);
        push(1, 32'd200, 0);
        push(0, 0, 1); push(0, 0, 1); push(0, 0, 1);
        push(1, 32'd300, 1);                     // din_vld on segment-end trig
        repeat (4) push(0, 0, 1);
        foreach (sv[i]) begin
            step(sv[i], sd[i], st[i]);
            checks++; if (dout !== e_dout) begin errors++; $display("FAIL t6_dout cyc %0d got %h want %h", i, dout, e_dout); end
            checks++; if ({underrun, overrun} !== {e_und, e_ovr}) begin errors++;
                $display("FAIL t6_pulses cyc %0d got %b want %b", i, {underrun, overrun}, {e_und, e_ovr}); end
            checks++; if (active !== e_act) begin errors++; $display("FAIL t6_active cyc %0d got %b want %b", i, active, e_act); end
        end
        checks++; if ((n_ovr != 0) || (n_und != 0)) begin errors++; $display("FAIL t6_no_pulses got ovr=%0d und=%0d want 0 0", n_ovr, n_und); end
        checks++; if (outs.size() != 8) begin errors++; $display("FAIL t6_count got %0d want 8", outs.size()); end
        else foreach (exp_o[i]) begin
            checks++; if (outs[i] != exp_o[i]) begin errors++; $display("FAIL t6_value %0d got %0d want %0d", i, outs[i], exp_o[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            d = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 2000)) - 1000);
            push($urandom_range(0, 5) == 0, d, $urandom_range(0, 1) == 1);
        end
        foreach (sv[i]) begin
            step(sv[i], sd[i], st[i]);
            checks++; if (dout !== e_dout) begin errors++; $display("FAIL rnd_dout cyc %0d got %h want %h", i, dout, e_dout); end
            checks++; if (dout_vld !== e_vld) begin errors++; $display("FAIL rnd_vld cyc %0d got %b want %b", i, dout_vld, e_vld); end
            checks++; if ({underrun, overrun} !== {e_und, e_ovr}) begin errors++;
                $display("FAIL rnd_pulses cyc %0d got %b want %b", i, {underrun, overrun}, {e_und, e_ovr}); end
            checks++; if (active !== e_act) begin errors++; $display("FAIL rnd_active cyc %0d got %b want %b", i, active, e_act); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_ramp();
        test_floor();
        test_extremes();
        test_overrun();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
